// File: rtl/jogador_automatico_exp3.sv
// rtl/jogador_automatico_exp3.sv - autonomous player driving the exp3 memory game from an answer ROM
module jogador_automatico_exp3 #(
    parameter int N_JOGADAS   = 16,
    parameter int HOLD_CYCLES = 1,
    parameter int GAP_CYCLES  = 1,
    parameter int TIMEOUT     = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic       inject_en,
    input  logic [3:0] inject_idx,
    input  logic       pronto,
    input  logic       acertou,
    input  logic       errou,
    output logic       iniciar,
    output logic [3:0] chaves,
    output logic       ocupado,
    output logic       fim,
    output logic       timeout,
    output logic       passou,
    output logic [3:0] db_indice,
    output logic [3:0] db_estado
);

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        PULSO     = 3'd1,
        ESPERA    = 3'd2,
        APRESENTA = 3'd3,
        SOLTA     = 3'd4,
        AGUARDA   = 3'd5,
        FIM       = 3'd6
    } estado_t;

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [3:0]    IDX_LAST  = 4'(N_JOGADAS - 1);

    estado_t       state_q;
    logic [3:0]    idx_q;
    logic [CW-1:0] cnt_q;
    logic [TW-1:0] tmo_q;
    logic          inj_en_q;
    logic [3:0]    inj_idx_q;
    logic          acertou_q;
    logic          errou_q;
    logic          timeout_q;
    logic          iniciar_q;
    logic [3:0]    chaves_q;

    logic [3:0]    idx_d;
    logic [3:0]    chaves_d;

    function automatic logic [3:0] rom_valor(input logic [3:0] i);
        case (i)
            4'd0:    rom_valor = 4'b0001;
            4'd1:    rom_valor = 4'b0010;
            4'd2:    rom_valor = 4'b0100;
            4'd3:    rom_valor = 4'b1000;
            4'd4:    rom_valor = 4'b0100;
            4'd5:    rom_valor = 4'b0010;
            4'd6:    rom_valor = 4'b0001;
            4'd7:    rom_valor = 4'b0001;
            4'd8:    rom_valor = 4'b0010;
            4'd9:    rom_valor = 4'b0010;
            4'd10:   rom_valor = 4'b0100;
            4'd11:   rom_valor = 4'b0100;
            4'd12:   rom_valor = 4'b1000;
            4'd13:   rom_valor = 4'b1000;
            4'd14:   rom_valor = 4'b0001;
            default: rom_valor = 4'b0100;
        endcase
    endfunction

    // Index and switch value of the next jogada to present; corrupted jogada is rotated left.
    always_comb begin
        idx_d    = (state_q == SOLTA) ? idx_q + 4'd1 : 4'd0;
        chaves_d = rom_valor(idx_d);
        if (inj_en_q && (idx_d == inj_idx_q)) begin
            chaves_d = {chaves_d[2:0], chaves_d[3]};
        end
    end

    // Main FSM with registered iniciar/chaves and captured game flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= OCIOSO;
            idx_q     <= 4'd0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            inj_en_q  <= 1'b0;
            inj_idx_q <= 4'd0;
            acertou_q <= 1'b0;
            errou_q   <= 1'b0;
            timeout_q <= 1'b0;
            iniciar_q <= 1'b0;
            chaves_q  <= 4'd0;
        end else begin
            iniciar_q <= 1'b0;
            case (state_q)
                OCIOSO, FIM: begin
                    if (partida) begin
                        state_q   <= PULSO;
                        inj_en_q  <= inject_en;
                        inj_idx_q <= inject_idx;
                        acertou_q <= 1'b0;
                        errou_q   <= 1'b0;
                        timeout_q <= 1'b0;
                        idx_q     <= 4'd0;
                        cnt_q     <= '0;
                        tmo_q     <= '0;
                        iniciar_q <= 1'b1;
                    end
                end
                PULSO: begin
                    state_q <= ESPERA;
                    idx_q   <= 4'd0;
                end
                ESPERA, APRESENTA, SOLTA, AGUARDA: begin
                    if (pronto) begin
                        // Game ended early: freeze idx and remember its verdict.
                        state_q   <= FIM;
                        acertou_q <= acertou;
                        errou_q   <= errou;
                        chaves_q  <= 4'd0;
                    end else if (state_q == ESPERA) begin
                        state_q  <= APRESENTA;
                        chaves_q <= chaves_d;
                        cnt_q    <= '0;
                    end else if (state_q == APRESENTA) begin
                        if (cnt_q == HOLD_LAST) begin
                            state_q  <= SOLTA;
                            chaves_q <= 4'd0;
                            cnt_q    <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end else if (state_q == SOLTA) begin
                        if (cnt_q == GAP_LAST) begin
                            cnt_q <= '0;
                            if (idx_q == IDX_LAST) begin
                                state_q <= AGUARDA;
                                tmo_q   <= '0;
                            end else begin
                                state_q  <= APRESENTA;
                                idx_q    <= idx_d;
                                chaves_q <= chaves_d;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end else begin
                        if (tmo_q == TMO_LAST) begin
                            state_q   <= FIM;
                            timeout_q <= 1'b1;
                        end else begin
                            tmo_q <= tmo_q + TW'(1);
                        end
                    end
                end
                default: begin
                    state_q  <= OCIOSO;
                    chaves_q <= 4'd0;
                end
            endcase
        end
    end

    assign iniciar   = iniciar_q;
    assign chaves    = chaves_q;
    assign ocupado   = (state_q != OCIOSO) && (state_q != FIM);
    assign fim       = (state_q == FIM);
    assign timeout   = timeout_q;
    assign passou    = !timeout_q && (inj_en_q ? (errou_q && !acertou_q) : (acertou_q && !errou_q));
    assign db_indice = idx_q;
    assign db_estado = {1'b0, state_q};

endmodule

// File: tb/tb_jogador_automatico_exp3.sv
// tb/tb_jogador_automatico_exp3.sv - self-checking bench for jogador_automatico_exp3
module tb_jogador_automatico_exp3;

    localparam int NJ   = 16;
    localparam int HOLD = 1;
    localparam int GAP  = 1;
    localparam int TMO  = 64;
    localparam int P      = HOLD + GAP;
    localparam int K_AG   = 2 + NJ * P;
    localparam int K_LAST = K_AG + TMO - 1;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       partida = 1'b0;
    logic       inject_en = 1'b0;
    logic [3:0] inject_idx = 4'd0;
    logic       pronto = 1'b0;
    logic       acertou = 1'b0;
    logic       errou = 1'b0;
    logic       iniciar;
    logic [3:0] chaves;
    logic       ocupado;
    logic       fim;
    logic       timeout;
    logic       passou;
    logic [3:0] db_indice;
    logic [3:0] db_estado;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    jogador_automatico_exp3 #(
        .N_JOGADAS(NJ), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
    ) dut (
        .clock(clock), .reset(reset), .partida(partida), .inject_en(inject_en),
        .inject_idx(inject_idx), .pronto(pronto), .acertou(acertou), .errou(errou),
        .iniciar(iniciar), .chaves(chaves), .ocupado(ocupado), .fim(fim),
        .timeout(timeout), .passou(passou), .db_indice(db_indice), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Reference model: mode 0 idle, 1 running (k = cycles since PULSO), 2 finished.
    int  m_mode = 0;
    int  m_k = 0;
    bit  m_ie = 0;
    int  m_ii = 0;
    int  m_idx = 0;
    bit  m_a = 0, m_e = 0, m_t = 0;
    int  rom_tab [16] = '{1, 2, 4, 8, 4, 2, 1, 1, 2, 2, 4, 4, 8, 8, 1, 4};

    function automatic int idx_at(input int k);
        if (k < 2) return 0;
        if (k >= K_AG) return NJ - 1;
        return (k - 2) / P;
    endfunction

    function automatic int valor(input int j);
        int v;
        v = rom_tab[j];
        if (m_ie && j == m_ii) v = ((v << 1) | (v >> 3)) & 15;
        return v;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_mode <= 0; m_k <= 0; m_ie <= 0; m_ii <= 0; m_idx <= 0;
            m_a <= 0; m_e <= 0; m_t <= 0;
        end else if (m_mode != 1) begin
            if (partida) begin
                m_mode <= 1; m_k <= 0; m_ie <= inject_en; m_ii <= int'(inject_idx);
                m_a <= 0; m_e <= 0; m_t <= 0;
            end
        end else if (m_k >= 1 && pronto) begin
            m_mode <= 2; m_a <= acertou; m_e <= errou; m_idx <= idx_at(m_k);
        end else if (m_k == K_LAST) begin
            m_mode <= 2; m_t <= 1; m_idx <= NJ - 1;
        end else begin
            m_k <= m_k + 1;
        end
    end

    // Expected {iniciar, chaves, ocupado, fim, timeout, passou, db_indice, db_estado}.
    function automatic logic [16:0] model_out();
        logic [3:0] ch, ix, st;
        logic ini, oc, fi, pa;
        int r;
        ch = 0; ix = 0; st = 0; ini = 0; oc = 0; fi = 0;
        pa = !m_t && (m_ie ? (m_e && !m_a) : (m_a && !m_e));
        if (m_mode == 2) begin
            fi = 1; st = 6; ix = 4'(m_idx);
        end else if (m_mode == 1) begin
            oc = 1;
            ix = 4'(idx_at(m_k));
            if (m_k == 0) begin
                st = 1; ini = 1;
            end else if (m_k == 1) begin
                st = 2;
            end else if (m_k < K_AG) begin
                r = (m_k - 2) % P;
                if (r < HOLD) begin
                    st = 3; ch = 4'(valor(idx_at(m_k)));
                end else begin
                    st = 4;
                end
            end else begin
                st = 5;
            end
        end
        return {ini, ch, oc, fi, m_t, pa, ix, st};
    endfunction

    always @(negedge clock) begin
        logic [16:0] exp_v, act_v;
        exp_v = model_out();
        act_v = {iniciar, chaves, ocupado, fim, timeout, passou, db_indice, db_estado};
        vectors++;
        if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL cycle_outputs t=%0t got %h expected %h", $time, act_v, exp_v);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s t=%0t got %0h expected %0h", nm, $time, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_run(input logic ie, input logic [3:0] ii);
        inject_en = ie; inject_idx = ii; partida = 1'b1;
        step();
        partida = 1'b0;
        cyc = 1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            step();
            cyc++;
        end
    endtask

    task automatic game_end(input logic a, input logic e);
        pronto = 1'b1; acertou = a; errou = e;
        step();
        pronto = 1'b0; acertou = 1'b0; errou = 1'b0;
        cyc++;
    endtask

    initial begin
        // Reset held for 2 cycles, then idle without partida.
        step(); step();
        reset = 1'b1;
        chk("reset_estado", 32'(db_estado), 0);
        chk("reset_outputs", {iniciar, chaves, ocupado, fim, timeout, passou, db_indice}, 0);
        repeat (4) step();
        chk("idle_estado", 32'(db_estado), 0);

        // Full correct run, echo game.
        start_run(1'b0, 4'd0);
        chk("run_iniciar_c1", 32'(iniciar), 1);
        goto(2);
        chk("run_iniciar_c2", 32'(iniciar), 0);
        goto(3);
        chk("run_chaves_c3", 32'(chaves), 4'b0001);
        goto(5);
        chk("run_chaves_c5", 32'(chaves), 4'b0010);
        goto(33);
        chk("run_chaves_c33", 32'(chaves), 4'b0100);
        goto(35);
        chk("run_aguarda_c35", 32'(db_estado), 5);
        goto(36);
        game_end(1'b1, 1'b0);
        chk("run_fim", {fim, passou, timeout}, 3'b110);
        chk("run_indice", 32'(db_indice), 15);

        // Injection at jogada 2; game reports errou.
        start_run(1'b1, 4'd2);
        goto(7);
        chk("inj_chaves_c7", 32'(chaves), 4'b1000);
        goto(8);
        game_end(1'b0, 1'b1);
        chk("inj_fim", {fim, passou}, 2'b11);
        chk("inj_indice", 32'(db_indice), 2);

        // Unexpected error at jogada 5.
        start_run(1'b0, 4'd0);
        goto(13);
        game_end(1'b0, 1'b1);
        chk("err_fim", {fim, passou}, 2'b10);
        chk("err_indice", 32'(db_indice), 5);

        // Timeout: AGUARDA begins in cycle 35, FIM must appear in cycle 99.
        start_run(1'b0, 4'd0);
        goto(98);
        chk("tmo_not_yet", 32'(fim), 0);
        goto(99);
        chk("tmo_fim", {fim, timeout, passou}, 3'b110);
        start_run(1'b0, 4'd0);
        chk("tmo_restart", {iniciar, timeout, fim}, 3'b100);

        // Reset mid-run during jogada 7.
        goto(17);
        chk("rst_chaves_pre", 32'(chaves), 4'b0001);
        reset = 1'b0;
        #1;
        chk("rst_immediate", {chaves, ocupado, iniciar}, 0);
        step();
        reset = 1'b1;
        repeat (3) step();
        chk("rst_release", {32'(db_estado), 32'(iniciar)}, 0);

        // Randomized traffic: partida, game flags and rare resets.
        for (int i = 0; i < 3000; i++) begin
            partida    = ($urandom_range(0, 15) == 0);
            pronto     = (i < 1500) ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 199) == 0);
            acertou    = 1'($urandom_range(0, 1));
            errou      = 1'($urandom_range(0, 1));
            inject_en  = 1'($urandom_range(0, 1));
            inject_idx = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
                step();
                reset = 1'b1;
            end else begin
                step();
            end
        end
        partida = 1'b0; pronto = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
